// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to imem, buffers returned words for the decoder.
// Latency: request accept to inst_valid = memory latency + 1 cycle (response registered into the buffer).
// Backpressure: requests are credit-limited so buffered + in-flight words never exceed FIFO_DEPTH.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   redirect_valid, redirect_pc        execute-stage redirect (PC load + flush)
//   imem_req_valid/ready/addr          fetch request channel (valid/ready)
//   imem_rsp_valid/data                in-order read response (always accepted)
//   inst_valid/ready, instruction,     decoder-facing buffer head (valid/ready)
//   inst_pc
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [31:0]     pc_q,   pc_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [PW-1:0]   aw_q,   ar_q;

  // Instruction buffer: word + the address it was fetched from.
  logic [31:0]     buf_dat_q [FIFO_DEPTH];
  logic [31:0]     buf_pc_q  [FIFO_DEPTH];
  // Addresses of in-flight requests, oldest first; popped by every response,
  // stale or not, so it stays aligned with the in-order memory.
  logic [31:0]     aq_q      [FIFO_DEPTH];

  logic            credit_ok;
  logic            req_acc;
  logic            rsp_acc;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [31:0]     redir_tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Every in-flight request owns a buffer slot, so the buffer can never overflow.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < CW1'(FIFO_DEPTH);

  assign imem_req_valid = (state_q != ST_RESET) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;

  assign req_acc  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is illegal and simply ignored.
  assign rsp_acc  = imem_rsp_valid && (infl_q != '0);
  assign rsp_drop = rsp_acc && (drop_q != '0);
  // On redirect the buffer is flushed, so neither a push nor a pop takes effect.
  assign push     = rsp_acc && !rsp_drop && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid  = (cnt_q != '0);
  assign instruction = inst_valid ? buf_dat_q[rptr_q] : 32'h0;
  assign inst_pc     = inst_valid ? buf_pc_q[rptr_q]  : 32'h0;

  always_comb begin
    pc_d   = pc_q;
    infl_d = infl_q + CW'(req_acc) - CW'(rsp_acc);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    drop_d = drop_q - CW'(rsp_drop);
    if (req_acc) begin
      pc_d = pc_q + 32'd4;
    end
    if (redirect_valid) begin
      pc_d   = redir_tgt;
      cnt_d  = '0;
      // Everything still outstanding after this cycle's response is stale.
      drop_d = infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      aw_q    <= '0;
      ar_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_dat_q[i] <= 32'h0;
        buf_pc_q[i]  <= 32'h0;
        aq_q[i]      <= 32'h0;
      end
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      drop_q <= drop_d;

      if (req_acc) begin
        aq_q[aw_q] <= pc_q;
        aw_q       <= ptr_inc(aw_q);
      end
      if (rsp_acc) begin
        ar_q <= ptr_inc(ar_q);
      end

      if (redirect_valid) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) begin
          buf_dat_q[wptr_q] <= imem_rsp_data;
          buf_pc_q[wptr_q]  <= aq_q[ar_q];
          wptr_q            <= ptr_inc(wptr_q);
        end
        if (pop) begin
          rptr_q <= ptr_inc(rptr_q);
        end
      end

      case (state_q)
        ST_RESET: state_q <= ST_RUN;
        ST_RUN: begin
          if (redirect_valid && (drop_d != '0)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drop_d == '0) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency plus a PC-sequence scoreboard.
// Latency: n/a (testbench).
// Backpressure: drives imem_req_ready and inst_ready from the test sequence.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          npops;
  int          lat_min;
  int          lat_max;
  bit          rdy_rand;
  bit          infl_chk;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0041_0093;
      32'h0000_0004: return 32'h0041_5093;
      default:       return {a[15:0], 16'h0013} ^ {16'h0, a[31:16]};
    endcase
  endfunction

  // Sample on the falling edge, advance one rising edge, then drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (infl_chk) chk_vec("infl_bound", 32'(dut.infl_q <= DEPTH), 32'd1);
      if (imem_rsp_valid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        chk_vec("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk_vec("inst_pc", inst_pc, exp_pc);
        chk_vec("instruction", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        npops++;
      end
      if (redirect_valid) begin
        exp_pc  = redirect_pc & 32'hFFFF_FFFC;
        exp_req = redirect_pc & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    if (rst_n && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic run_pops(input int n, input int budget, input string tag);
    int target;
    int k;
    target = npops + n;
    k = 0;
    while (npops < target && k < budget) begin
      tick();
      k++;
    end
    chk_vec(tag, 32'(npops >= target), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; cyc = 0; npops = 0;
    lat_min = 1; lat_max = 1; rdy_rand = 0; infl_chk = 0;
    exp_pc = RPC; exp_req = RPC;
    redirect_valid = 0; redirect_pc = 0; imem_req_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;

    // 1: reset state, then two zero-wait fetches in order
    chk_vec("rst_req_vld",  32'(imem_req_valid), 32'd0);
    chk_vec("rst_inst_vld", 32'(inst_valid),     32'd0);
    chk_vec("rst_instr",    instruction,         32'h0);
    chk_vec("rst_inst_pc",  inst_pc,             32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk_vec("first_req_vld",  32'(imem_req_valid), 32'd1);
    chk_vec("first_req_addr", imem_req_addr,       RPC);
    chk_vec("early_inst_vld", 32'(inst_valid),     32'd0);
    inst_ready = 1'b1;
    run_pops(2, 20, "t1_two_words");

    // 2: decoder stall fills the buffer and stops requests
    inst_ready = 1'b0;
    repeat (10) tick();
    chk_vec("stall_req_vld", 32'(imem_req_valid), 32'd0);
    chk_vec("stall_count",   32'(dut.cnt_q),      32'(DEPTH));
    chk_vec("stall_inst_vld", 32'(inst_valid),    32'd1);
    inst_ready = 1'b1;
    run_pops(4, 30, "t2_resume");

    // 3: redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    k = 0;
    while (dut.infl_q != 2 && k < 20) begin tick(); k++; end
    chk_vec("t3_infl2", 32'(dut.infl_q), 32'd2);
    do_redirect(32'h0000_0100);
    chk_vec("t3_drain", 32'(dut.state_q), 32'd2);
    k = 0;
    while (!inst_valid && k < 20) begin tick(); k++; end
    chk_vec("t3_head_pc", inst_pc, 32'h0000_0100);
    run_pops(2, 30, "t3_stream");
    chk_vec("t3_run", 32'(dut.state_q), 32'd1);

    // 4: unaligned target, wrap around the top of memory, back-to-back redirects
    lat_min = 1; lat_max = 1;
    do_redirect(32'h0000_0103);
    chk_vec("t4_align", imem_req_addr, 32'h0000_0100);
    run_pops(3, 30, "t4_stream_100");
    do_redirect(32'hFFFF_FFFC);
    chk_vec("t4_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    run_pops(3, 30, "t4_wrap_stream");
    do_redirect(32'h0000_0200);
    do_redirect(32'h0000_0300);
    chk_vec("t4_last_wins", imem_req_addr, 32'h0000_0300);
    run_pops(3, 30, "t4_b2b_stream");

    // 5: random memory readiness, latency 1..3, random decoder readiness
    lat_min = 1; lat_max = 3; rdy_rand = 1; infl_chk = 1;
    for (int i = 0; i < 300; i++) begin
      inst_ready = 1'($urandom_range(1, 0));
      tick();
    end
    inst_ready = 1'b1;
    run_pops(2, 40, "t5_tail");
    infl_chk = 0; rdy_rand = 0; lat_min = 1; lat_max = 1;

    // 6: async reset with a full buffer, stale response right after release
    inst_ready = 1'b0;
    repeat (10) tick();
    chk_vec("t6_full", 32'(dut.cnt_q), 32'(DEPTH));
    #3 rst_n = 1'b0;
    #1;
    chk_vec("t6_rst_inst_vld", 32'(inst_valid),     32'd0);
    chk_vec("t6_rst_req_vld",  32'(imem_req_valid), 32'd0);
    chk_vec("t6_rst_instr",    instruction,         32'h0);
    mq_addr.delete();
    mq_due.delete();
    exp_pc = RPC; exp_req = RPC;
    repeat (2) tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    run_pops(3, 30, "t6_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
